// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a four-digit, common-anode seven-segment display.
// Digits are scanned with a blanking gap between them; new data switches in only at frame boundaries.
module seven_seg_scanner #(
  parameter int REFRESH_CYCLES = 5000,
  parameter int BLANK_CYCLES   = 50
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data,
  input  logic        load,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        pending,
  output logic        frame_done
);

  localparam int MAX_CYC = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      active_q, active_d;
  logic [15:0]      pbuf_q, pbuf_d;
  logic             pending_q, pending_d;
  logic             fdone_q, fdone_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             boundary;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_BLANK;
      idx_q     <= 2'd0;
      cnt_q     <= '0;
      active_q  <= 16'h0000;
      pbuf_q    <= 16'h0000;
      pending_q <= 1'b0;
      fdone_q   <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pbuf_q    <= pbuf_d;
      pending_q <= pending_d;
      fdone_q   <= fdone_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CNT_W'(1);
    boundary = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d  = ST_BLANK;
          cnt_d    = '0;
          idx_d    = idx_q + 2'd1;
          boundary = (idx_q == 2'd3);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // The boundary copy reads the pre-edge pending buffer, so a coincident load lands for the next frame.
  always_comb begin
    pbuf_d    = load ? data : pbuf_q;
    pending_d = load | (pending_q & ~boundary);
    active_d  = (boundary && pending_q) ? pbuf_q : active_q;
    fdone_d   = boundary;
  end

  // Outputs are derived from the next state so they switch on the same edge as the FSM.
  always_comb begin
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    if (state_d == ST_SHOW) begin
      an_d  = 4'b1111 ^ (4'b0001 << idx_d);
      seg_d = hex_to_seg(active_q[{idx_d, 2'b00} +: 4]);
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign pending    = pending_q;
  assign frame_done = fdone_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with a short refresh (4) and blank (2) period.
// Each frame is 24 cycles; digit k is lit from offset 2+6k to 5+6k after a frame boundary.
module tb_seven_seg_scanner;

  localparam int RC = 4;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        pending;
  logic        frame_done;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .REFRESH_CYCLES(RC),
    .BLANK_CYCLES  (BC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data      (data),
    .load      (load),
    .an        (an),
    .seg       (seg),
    .pending   (pending),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs nsteps edges starting just after a frame boundary (or reset release).
  task automatic run_frame(input logic [15:0] show, input int nsteps,
                           input int ld1_off, input logic [15:0] ld1_val,
                           input int ld2_off, input logic [15:0] ld2_val,
                           input logic pend_end);
    int   fd_cnt;
    logic bad;
    fd_cnt = 0;
    bad    = 1'b0;
    for (int o = 1; o <= nsteps; o++) begin
      if (o - 1 == ld1_off) begin
        load = 1'b1;
        data = ld1_val;
      end else if (o - 1 == ld2_off) begin
        load = 1'b1;
        data = ld2_val;
      end else begin
        load = 1'b0;
      end
      step();
      if (frame_done) fd_cnt++;
      if (!(an == 4'hF || $onehot(~an))) bad = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (o == 2 + 6 * k) begin
          chk("an_show", an, 4'hF ^ (4'h1 << k));
          chk("seg_show", seg, DEC[show[4*k +: 4]]);
        end
        if (o == 6 + 6 * k) chk("an_blank", an, 4'hF);
      end
      if (o == ld1_off + 1 || o == ld2_off + 1) chk("pend_set", pending, 1);
      if (o == nsteps && nsteps == 24) begin
        chk("fdone_pulse", frame_done, 1);
        chk("pend_end", pending, pend_end);
        chk("fdone_count", fd_cnt, 1);
      end
    end
    chk("an_valid", bad, 0);
    load = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_pending", pending, 0);
    chk("rst_fdone", frame_done, 0);
    reset = 1'b1;

    // Frame 1: zeros shown; 1F80 loaded mid-frame, switched in at the boundary
    run_frame(16'h0000, 24, 8, 16'h1F80, -1, 16'h0000, 1'b0);
    // Frame 2: two loads, last one wins
    run_frame(16'h1F80, 24, 3, 16'h1111, 10, 16'h2222, 1'b0);
    // Frame 3: 3333 pending, 4444 loaded on the boundary edge
    run_frame(16'h2222, 24, 5, 16'h3333, 23, 16'h4444, 1'b1);
    run_frame(16'h3333, 24, -1, 16'h0000, -1, 16'h0000, 1'b0);
    run_frame(16'h4444, 24, -1, 16'h0000, -1, 16'h0000, 1'b0);
    run_frame(16'h4444, 24, -1, 16'h0000, -1, 16'h0000, 1'b0);

    // Reset asserted while digit 2 is lit, with a load pending
    run_frame(16'h4444, 15, 10, 16'h5555, -1, 16'h0000, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_seg", seg, 7'h7F);
    chk("async_pending", pending, 0);
    chk("async_fdone", frame_done, 0);
    #2;
    reset = 1'b1;
    run_frame(16'h0000, 24, -1, 16'h0000, -1, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
